// File: rtl/stream_frame_checker_pkg.sv
// Shared video package: default frame geometry and the frame checker state type.
// X_SIZE/Y_SIZE are the generator's frame size; the checker derives its
// default line length in 32-bit words from them.
package stream_frame_checker_pkg;

    localparam int X_SIZE    = 640;
    localparam int Y_SIZE    = 480;
    localparam int BPP       = 24;
    localparam int WORD_BITS = 32;

    // 640 px x 24 bpp / 32 = 480 words per line
    localparam int WORDS_PER_LINE_DEF  = (X_SIZE * BPP) / WORD_BITS;
    localparam int LINES_PER_FRAME_DEF = Y_SIZE;

    typedef enum logic {
        SEEK  = 1'b0,
        FRAME = 1'b1
    } state_t;

endpackage

// File: rtl/stream_frame_checker_if.sv
// Video stream bus (AXI4-Stream style, 32-bit data).
//   tdata  : pixel data word
//   tkeep  : byte enables (not interpreted by the checker)
//   tlast  : end of line
//   tuser  : start of frame
//   tvalid : source has a beat
//   tready : sink accepts the beat
// master drives the beat, slave drives tready.
interface stream_frame_checker_if;

    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;

    modport master (
        output tdata, tkeep, tlast, tuser, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tuser, tvalid,
        output tready
    );

endinterface

// File: rtl/stream_frame_checker.sv
// Video frame checker: locks onto start-of-frame, checks line lengths against
// tlast, sums every word of a frame and reports good frames and framing errors.
// Ports:
//   aclk            : clock, rising edge
//   rst             : asynchronous active-high reset
//   sink_en         : enables acceptance of stream beats (drives tready)
//   err_clr         : synchronous clear of err_count
//   in_stream       : stream input bus (slave side)
//   frame_done      : one-cycle pulse after a complete well-formed frame
//   frame_checksum  : mod-2^32 sum of the last good frame
//   frame_count     : good frame count, wraps
//   err_sof         : pulse, start-of-frame seen inside a frame
//   err_eol_early   : pulse, tlast before the last word of a line
//   err_eol_missing : pulse, no tlast on the last word of a line
//   err_count       : total error pulses, saturating
module stream_frame_checker
    import stream_frame_checker_pkg::*;
#(
    parameter int WORDS_PER_LINE  = WORDS_PER_LINE_DEF,
    parameter int LINES_PER_FRAME = LINES_PER_FRAME_DEF
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic                  sink_en,
    input  logic                  err_clr,
    stream_frame_checker_if.slave in_stream,
    output logic                  frame_done,
    output logic [31:0]           frame_checksum,
    output logic [15:0]           frame_count,
    output logic                  err_sof,
    output logic                  err_eol_early,
    output logic                  err_eol_missing,
    output logic [15:0]           err_count
);

    localparam int WW = (WORDS_PER_LINE  > 1) ? $clog2(WORDS_PER_LINE)  : 1;
    localparam int LW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

    localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_LINE - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(LINES_PER_FRAME - 1);

    state_t        state, state_n;
    logic [WW-1:0] word_cnt, word_cnt_n;
    logic [LW-1:0] line_cnt, line_cnt_n;
    logic [31:0]   sum, sum_n;
    logic          done_n, sof_n, early_n, missing_n, err_n;
    logic          beat;
    logic          unused_tkeep;

    assign in_stream.tready = sink_en;
    assign beat             = in_stream.tvalid & sink_en;
    assign unused_tkeep     = ^in_stream.tkeep;
    assign err_n            = sof_n | early_n | missing_n;

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state <= SEEK;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        word_cnt_n = word_cnt;
        line_cnt_n = line_cnt;
        sum_n      = sum;
        done_n     = 1'b0;
        sof_n      = 1'b0;
        early_n    = 1'b0;
        missing_n  = 1'b0;

        if (beat) begin
            // A start-of-frame beat always becomes word 0 of line 0; inside a
            // frame it is flagged first, which masks any EOL check on that beat.
            if (in_stream.tuser) begin
                sof_n      = (state == FRAME);
                state_n    = FRAME;
                sum_n      = in_stream.tdata;
                word_cnt_n = WW'(1);
                line_cnt_n = '0;
            end else if (state == FRAME) begin
                sum_n      = sum + in_stream.tdata;
                word_cnt_n = word_cnt + WW'(1);
                if (word_cnt == LAST_WORD) begin
                    if (in_stream.tlast) begin
                        word_cnt_n = '0;
                        if (line_cnt == LAST_LINE) begin
                            done_n  = 1'b1;
                            state_n = SEEK;
                        end else begin
                            line_cnt_n = line_cnt + LW'(1);
                        end
                    end else begin
                        missing_n = 1'b1;
                        state_n   = SEEK;
                    end
                end else if (in_stream.tlast) begin
                    early_n = 1'b1;
                    state_n = SEEK;
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            word_cnt        <= '0;
            line_cnt        <= '0;
            sum             <= '0;
            frame_done      <= 1'b0;
            frame_checksum  <= '0;
            frame_count     <= '0;
            err_sof         <= 1'b0;
            err_eol_early   <= 1'b0;
            err_eol_missing <= 1'b0;
            err_count       <= '0;
        end else begin
            word_cnt        <= word_cnt_n;
            line_cnt        <= line_cnt_n;
            sum             <= sum_n;
            frame_done      <= done_n;
            err_sof         <= sof_n;
            err_eol_early   <= early_n;
            err_eol_missing <= missing_n;
            if (done_n) begin
                frame_checksum <= sum_n;
                frame_count    <= frame_count + 16'd1;
            end
            // Counted alongside the pulse it accompanies; clear has priority.
            if (err_clr) begin
                err_count <= '0;
            end else if (err_n && (err_count != '1)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule
